sift_extreme_scheduler: RTL and testbench

Sequences the shared `local_extreme` detector across the DoG scale stack of one octave. For each interior scale s it selects the layer triplet (s-1, s, s+1) and streams pixel addresses in raster order to the DoG memories. It enables `local_extreme` through `complete1` and tags each extremum flag with its pixel coordinates and scale, so that downstream keypoint refinement receives (x, y, s) records over a valid/ready handshake.

---
 rtl/sift_extreme_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_sift_extreme_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sift_extreme_scheduler.sv
// sift_extreme_scheduler: runs the shared local_extreme detector over every
// interior DoG triplet of one octave. It streams raster pixel addresses, tags
// each detector result with (x, y, s) and hands out keypoint records over a
// single-entry valid/ready output register.
module sift_extreme_scheduler #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int NUM_DOG = 5,
  parameter int LAT     = 3,
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int SW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [XW+YW-1:0]   rd_addr,
  output logic               rd_en,
  output logic [SW-1:0]      sel0,
  output logic [SW-1:0]      sel1,
  output logic [SW-1:0]      sel2,
  output logic               complete1,
  input  logic               ext_en,
  input  logic               ext_flag,
  output logic               kp_valid,
  input  logic               kp_ready,
  output logic [XW-1:0]      kp_x,
  output logic [YW-1:0]      kp_y,
  output logic [SW-1:0]      kp_s,
  output logic [15:0]        kp_count,
  output logic               busy,
  output logic               done
);

  localparam int DW = $clog2(LAT + 2);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 2);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_DOG - 2);
  localparam logic [DW-1:0] D_LAST = DW'(LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_NEXT,
    ST_FINISH
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [SW-1:0]   r_s;
  logic [DW-1:0]   r_drain;

  logic [XW-1:0]   r_tag_x [LAT+1];
  logic [YW-1:0]   r_tag_y [LAT+1];

  logic            r_kp_valid;
  logic [XW-1:0]   r_kp_x;
  logic [YW-1:0]   r_kp_y;
  logic [SW-1:0]   r_kp_s;
  logic [15:0]     r_kp_count;

  logic            w_en;
  logic            w_scan;
  logic            w_drain;
  logic            w_start_acc;
  logic [XW-1:0]   w_tx;
  logic [YW-1:0]   w_ty;
  logic            w_interior;
  logic            w_hit;

  // A pending record that downstream refuses freezes the whole pass.
  assign w_en        = !(r_kp_valid && !kp_ready);
  assign w_scan      = (r_state == ST_SCAN);
  assign w_drain     = (r_state == ST_DRAIN);
  assign w_start_acc = (r_state == ST_IDLE) && start && w_en;

  assign rd_en     = w_en && w_scan;
  assign complete1 = w_en && (w_scan || w_drain);
  assign rd_addr   = {r_y, r_x};
  assign sel0      = r_s - SW'(1);
  assign sel1      = r_s;
  assign sel2      = r_s + SW'(1);
  assign busy      = (r_state == ST_SCAN) || (r_state == ST_DRAIN) || (r_state == ST_NEXT);
  assign done      = (r_state == ST_FINISH);

  assign kp_valid = r_kp_valid;
  assign kp_x     = r_kp_x;
  assign kp_y     = r_kp_y;
  assign kp_s     = r_kp_s;
  assign kp_count = r_kp_count;

  // Tag at the end of the pipe belongs to the detector result on ext_en.
  // complete1 gating keeps a frozen or stale ext_en from loading twice.
  assign w_tx       = r_tag_x[LAT];
  assign w_ty       = r_tag_y[LAT];
  assign w_interior = (w_tx >= XW'(1)) && (w_tx <= X_MAX) &&
                      (w_ty >= YW'(1)) && (w_ty <= Y_MAX);
  assign w_hit      = complete1 && ext_en && ext_flag && w_interior;

  // Pass sequencer: raster scan per triplet, drain, step scale, finish.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= SW'(1);
      r_drain <= '0;
    end else if (w_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s     <= SW'(1);
            r_x     <= '0;
            r_y     <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y == Y_LAST) begin
              r_y     <= '0;
              r_drain <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_y <= r_y + YW'(1);
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == D_LAST) begin
            r_state <= ST_NEXT;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        ST_NEXT: begin
          if (r_s == S_LAST) begin
            r_state <= ST_FINISH;
          end else begin
            r_s     <= r_s + SW'(1);
            r_x     <= '0;
            r_y     <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Coordinate tag pipe, advancing in lockstep with memory stage + detector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        r_tag_x[i] <= '0;
        r_tag_y[i] <= '0;
      end
    end else if (complete1) begin
      r_tag_x[0] <= r_x;
      r_tag_y[0] <= r_y;
      for (int unsigned i = 1; i <= LAT; i++) begin
        r_tag_x[i] <= r_tag_x[i-1];
        r_tag_y[i] <= r_tag_y[i-1];
      end
    end
  end

  // Single-entry keypoint register; a new record wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kp_valid <= 1'b0;
      r_kp_x     <= '0;
      r_kp_y     <= '0;
      r_kp_s     <= '0;
      r_kp_count <= '0;
    end else begin
      if (w_hit) begin
        r_kp_valid <= 1'b1;
        r_kp_x     <= w_tx;
        r_kp_y     <= w_ty;
        r_kp_s     <= r_s;
        if (r_kp_count != '1) begin
          r_kp_count <= r_kp_count + 16'd1;
        end
      end else if (r_kp_valid && kp_ready) begin
        r_kp_valid <= 1'b0;
      end
      if (w_start_acc) begin
        r_kp_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sift_extreme_scheduler.sv
// tb_sift_extreme_scheduler: drives octave passes against an emulated DoG
// memory + local_extreme detector and checks addresses, scale selects,
// keypoint records, pass timing, stalls, start filtering and reset abort.
module tb_sift_extreme_scheduler;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int ND   = 4;
  localparam int LAT  = 3;
  localparam int XW   = 8;
  localparam int YW   = 8;
  localparam int SW   = 3;
  localparam int NPIX = W * H;
  localparam int NSC  = ND - 2;
  localparam int PASS_CYC = NSC * (NPIX + LAT + 2) + 1;

  typedef logic [XW+YW+SW-1:0] rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             kp_ready = 1'b1;
  logic             ext_en;
  logic             ext_flag;
  logic [XW+YW-1:0] rd_addr;
  logic             rd_en;
  logic [SW-1:0]    sel0, sel1, sel2;
  logic             complete1;
  logic             kp_valid;
  logic [XW-1:0]    kp_x;
  logic [YW-1:0]    kp_y;
  logic [SW-1:0]    kp_s;
  logic [15:0]      kp_count;
  logic             busy;
  logic             done;

  sift_extreme_scheduler #(
    .IMG_W(W), .IMG_H(H), .NUM_DOG(ND), .LAT(LAT), .XW(XW), .YW(YW), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .complete1(complete1), .ext_en(ext_en), .ext_flag(ext_flag),
    .kp_valid(kp_valid), .kp_ready(kp_ready),
    .kp_x(kp_x), .kp_y(kp_y), .kp_s(kp_s),
    .kp_count(kp_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Extremum map per (scale, y, x) for the current pass.
  bit flag_tab [ND][H][W];

  function automatic bit flag_at(input int s, input int y, input int x);
    if (s < 0 || s >= ND || y < 0 || y >= H || x < 0 || x >= W) return 1'b0;
    return flag_tab[s][y][x];
  endfunction

  // Environment: one-cycle memory stage then a LAT-deep detector, both
  // advancing only when complete1 is high. Captures what is being read.
  logic          dv [LAT+1];
  logic          df [LAT+1];
  logic          noise;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 1'($urandom_range(0, 1));
    if (!rst) begin
      for (int k = 0; k <= LAT; k++) begin
        dv[k] <= 1'b0;
        df[k] <= 1'b0;
      end
    end else if (complete1) begin
      dv[0] <= rd_en;
      df[0] <= flag_at(int'(sel1), int'(rd_addr[XW+YW-1:XW]), int'(rd_addr[XW-1:0]));
      for (int k = 1; k <= LAT; k++) begin
        dv[k] <= dv[k-1];
        df[k] <= df[k-1];
      end
    end
  end

  assign ext_en   = dv[LAT];
  assign ext_flag = ext_en ? df[LAT] : noise;

  // Reference: ordered list of records the pass must emit.
  rec_t exp_q[$];
  int   n_exp;
  int   issue_idx;
  int   t_issue;
  int   t_valid;

  task automatic set_flags(input int mode);
    for (int s = 0; s < ND; s++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          case (mode)
            0: flag_tab[s][y][x] = 1'b0;
            1: flag_tab[s][y][x] = 1'b1;
            2: flag_tab[s][y][x] = (s == 1 && y == 2 && x == 3);
            default: flag_tab[s][y][x] = ($urandom_range(0, 99) < 30);
          endcase
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int s = 1; s <= ND - 2; s++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (flag_tab[s][y][x] && x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2)
            exp_q.push_back({XW'(x), YW'(y), SW'(s)});
    n_exp = exp_q.size();
  endtask

  // Monitor: every issued address and every accepted record.
  int               m_p;
  int               m_sc;
  logic [XW+YW-1:0] m_ea;
  logic             prev_kpv = 1'b0;
  rec_t             m_rec;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (rd_en) begin
        if (issue_idx >= NPIX * NSC) begin
          chk("rd_extra", 1, 0);
        end else begin
          m_p  = issue_idx % NPIX;
          m_sc = 1 + issue_idx / NPIX;
          m_ea = {YW'(m_p / W), XW'(m_p % W)};
          chk("rd_addr", rd_addr, m_ea);
          chk("sel", {sel0, sel1, sel2}, {SW'(m_sc - 1), SW'(m_sc), SW'(m_sc + 1)});
        end
        if (rd_addr == {YW'(2), XW'(3)} && sel1 == SW'(1)) t_issue = cyc;
        issue_idx++;
      end
      if (kp_valid && !prev_kpv && t_valid < 0) t_valid = cyc;
      if (kp_valid && kp_ready) begin
        if (exp_q.size() == 0) begin
          chk("kp_extra", {kp_x, kp_y, kp_s}, 0);
        end else begin
          m_rec = exp_q.pop_front();
          chk("kp_rec", {kp_x, kp_y, kp_s}, m_rec);
        end
      end
    end
    prev_kpv = kp_valid;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_sel"}, {sel0, sel1, sel2}, {SW'(0), SW'(1), SW'(2)});
    chk({tag, "_complete1"}, complete1, 0);
    chk({tag, "_kp_valid"}, kp_valid, 0);
    chk({tag, "_kp_xys"}, {kp_x, kp_y, kp_s}, 0);
    chk({tag, "_kp_count"}, kp_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // fmode: flag map; smode: 0 ready=1, 1 random ready, 2 one 10-cycle hold.
  task automatic run_pass(input int fmode, input int smode, input bit busy_start,
                          input int abort_pix, input int exp_cyc, input bit done_start);
    int               n;
    int               hold;
    bit               held_done;
    bit               aborted;
    logic [XW+YW-1:0] held_addr;
    logic [XW+YW-1:0] abort_addr;
    set_flags(fmode);
    build_expected();
    issue_idx = 0;
    t_issue   = -1;
    t_valid   = -1;
    kp_ready  = 1'b1;
    start     = 1'b1;
    n = 0; hold = 0; held_done = 0; aborted = 0; held_addr = '0;
    abort_addr = {YW'(abort_pix / W), XW'(abort_pix % W)};
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy_start && n == 30) start = 1'b1;
      if (busy_start && n == 31) start = 1'b0;
      if (smode == 1) kp_ready = ($urandom_range(0, 3) != 0);
      if (smode == 2) begin
        if (hold == 0 && held_done) kp_ready = 1'b1;
        if (!held_done && kp_valid) begin
          kp_ready  = 1'b0;
          hold      = 10;
          held_done = 1'b1;
          held_addr = rd_addr;
        end
      end
      if (abort_pix >= 0 && rd_en && rd_addr == abort_addr) begin
        rst     = 1'b0;
        aborted = 1'b1;
      end
      #2;
      if (n == 1) begin
        chk("start_kp_count", kp_count, 0);
        chk("start_busy", busy, 1);
        chk("start_rd_en", rd_en, 1);
      end
      if (hold > 0) begin
        chk("stall_complete1", complete1, 0);
        chk("stall_rd_en", rd_en, 0);
        chk("stall_rd_addr", rd_addr, held_addr);
        hold--;
      end
      if (aborted || done) break;
    end
    if (aborted) begin
      @(negedge clk);
      #2;
      check_reset_vals("abort");
      rst = 1'b1;
    end else if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (exp_cyc >= 0) chk("pass_cycles", n, exp_cyc);
      chk("done_busy", busy, 0);
      chk("kp_count", kp_count, n_exp);
      chk("exp_left", exp_q.size(), 0);
      chk("issues", issue_idx, NPIX * NSC);
      if (fmode == 2) chk("latency", t_valid - t_issue, LAT + 2);
      if (done_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("done_start_busy", busy, 0);
        chk("done_start_rd_en", rd_en, 0);
        chk("done_start_done", done, 0);
      end
    end
    kp_ready = 1'b1;
  endtask

  initial begin
    issue_idx = 0;
    t_issue   = -1;
    t_valid   = -1;
    n_exp     = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_vals("por");
    rst = 1'b1;
    @(negedge clk);
    // No extrema: pure address sweep and exact pass length.
    run_pass(0, 0, 1'b0, -1, PASS_CYC, 1'b0);
    repeat (2) @(negedge clk);
    // Every pixel flagged, start pulsed mid-pass and in the done cycle.
    run_pass(1, 0, 1'b1, -1, PASS_CYC, 1'b1);
    // Starts one cycle after done: single forced extremum and its latency.
    run_pass(2, 0, 1'b0, -1, PASS_CYC, 1'b0);
    repeat (2) @(negedge clk);
    // Downstream holds off for 10 cycles on the first record.
    run_pass(1, 2, 1'b0, -1, PASS_CYC + 10, 1'b0);
    repeat (2) @(negedge clk);
    // Reset while scanning pixel 20 of the first triplet.
    run_pass(1, 0, 1'b0, 20, -1, 1'b0);
    repeat (2) @(negedge clk);
    // Random extrema under random back-pressure, then without it.
    run_pass(3, 1, 1'b0, -1, -1, 1'b0);
    repeat (2) @(negedge clk);
    run_pass(3, 0, 1'b0, -1, PASS_CYC, 1'b0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
